// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
// State encoding, grant encoding and the latched memory command.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_cmd_t;

    // Round-robin pick: on contention the side not served last wins.
    function automatic grant_t pick_grant(
        input logic   f_pend,
        input logic   d_pend,
        input grant_t last
    );
        grant_t g;
        g = GNT_FETCH;
        if (f_pend && d_pend) begin
            if (last == GNT_FETCH) g = GNT_DATA;
            else                   g = GNT_FETCH;
        end else if (d_pend) begin
            g = GNT_DATA;
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port unified memory.
// One access in flight; fixed LATENCY from mem_en to read data.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ready,
    output logic        if_stall,
    input  logic        d_re,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ready,
    output logic        d_stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t   state;
    state_t   state_nx;
    grant_t   last_grant;
    grant_t   gnt;
    mem_cmd_t cmd;
    logic [3:0] cnt;
    logic     d_pend;
    logic     busy;
    logic     grant_go;
    logic     capture;

    assign d_pend = d_re | d_we;
    assign busy   = (state == FETCH) || (state == DATA);

    // Next-state: grant from IDLE, count down while busy, one RESP cycle.
    always_comb begin
        state_nx = state;
        grant_go = 1'b0;
        capture  = 1'b0;
        gnt      = pick_grant(if_req, d_pend, last_grant);
        case (state)
            IDLE: begin
                if (if_req || d_pend) begin
                    grant_go = 1'b1;
                    if (gnt == GNT_DATA) state_nx = DATA;
                    else                 state_nx = FETCH;
                end
            end
            FETCH, DATA: begin
                if (cnt == 4'd1) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Grant bookkeeping: latch the winner's command and load the countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 4'd0;
            last_grant <= GNT_FETCH;
            cmd        <= '0;
        end else if (grant_go) begin
            cnt        <= LAT;
            last_grant <= gnt;
            cmd.we     <= (gnt == GNT_DATA) && d_we;
            cmd.wdata  <= d_wdata;
            if (gnt == GNT_DATA) cmd.addr <= d_addr;
            else                 cmd.addr <= if_addr;
        end else if (busy) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response registers hold until the next read for that requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata <= 16'h0000;
            d_rdata  <= 16'h0000;
        end else if (capture) begin
            if (last_grant == GNT_FETCH) if_rdata <= mem_rdata;
            else if (!cmd.we)            d_rdata  <= mem_rdata;
        end
    end

    // Memory command is valid only in the first busy cycle.
    always_comb begin
        mem_en    = busy && (cnt == LAT);
        mem_we    = mem_en && cmd.we;
        mem_addr  = cmd.addr;
        mem_wdata = cmd.wdata;
    end

    // Ready pulses in RESP; stalls are held off while in reset.
    always_comb begin
        if_ready = (state == RESP) && (last_grant == GNT_FETCH);
        d_ready  = (state == RESP) && (last_grant == GNT_DATA);
        if_stall = ~rst & if_req & ~if_ready;
        d_stall  = ~rst & d_pend & ~d_ready;
    end

endmodule
